// File: rtl/tlb_access_sched.sv
// tlb_access_sched: arbitrates IF/MEM lookups and CP0 TLB ops onto the single TLB port, and keeps CP0 Random.
// Optional counters are built when TLB_SCHED_PERF_EN is defined.
`default_nettype none

module tlb_access_sched #(
  parameter int TLB_ENTRIES = 32,
  parameter int IDX_W       = 5,
  parameter int STARVE_MAX  = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             if_req,
  input  logic [19:0]      if_vpn,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             dm_req,
  input  logic [19:0]      dm_vpn,
  input  logic             dm_wr,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  input  logic             op_req,
  input  logic [1:0]       op_code,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  output logic [IDX_W-1:0] random,
  output logic             op_done,
  output logic             lk_valid,
  output logic [19:0]      lk_vpn,
  output logic             lk_sel,
  output logic             lk_wr,
  output logic             mg_en,
  output logic [1:0]       mg_code,
  output logic [IDX_W-1:0] mg_index,
  input  logic             mg_ack
`ifdef TLB_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_lookups,
  output logic [31:0]      perf_conflicts,
  output logic [31:0]      perf_op_stall
`endif
);

  localparam int               SW       = $clog2(STARVE_MAX + 1);
  localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] OP_TLBP  = 2'd0;
  localparam logic [1:0] OP_TLBWR = 2'd3;

  // S_DONE carries the op_done pulse; S_FENCE follows it so CP0 has dropped
  // op_req before the scheduler is back in S_IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_FENCE = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic [IDX_W-1:0] random_q, random_d;
  logic [1:0]       code_q, code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             if_rvalid_q, if_rvalid_d;
  logic             dm_rvalid_q, dm_rvalid_d;
  logic [IDX_W-1:0] issue_idx;

  // Arbitration: grants are combinational so a held request is accepted
  // exactly once; gating with resetn keeps every strobe low during reset.
  always_comb begin
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    starve_d = starve_q;
    if (state_q == S_IDLE && resetn) begin
      if (dm_req && if_req) begin
        if (starve_q >= STARVE_LIM) begin
          if_gnt   = 1'b1;
          starve_d = '0;
        end else begin
          dm_gnt   = 1'b1;
          starve_d = starve_q + SW'(1);
        end
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt   = 1'b1;
        starve_d = '0;
      end
    end
  end

  always_comb begin
    lk_valid    = if_gnt | dm_gnt;
    lk_sel      = dm_gnt;
    lk_wr       = dm_gnt & dm_wr;
    lk_vpn      = dm_gnt ? dm_vpn : (if_gnt ? if_vpn : 20'd0);
    if_rvalid_d = if_gnt;
    dm_rvalid_d = dm_gnt;
  end

  always_comb begin
    case (code_q)
      OP_TLBP:  issue_idx = '0;
      OP_TLBWR: issue_idx = random_q;
      default:  issue_idx = cp0_index;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    mg_en    = 1'b0;
    op_done  = 1'b0;
    mg_index = idx_q;
    case (state_q)
      S_IDLE: begin
        if (op_req) begin
          state_d = S_DRAIN;
          code_d  = op_code;
        end
      end
      S_DRAIN: state_d = S_ISSUE;
      S_ISSUE: begin
        mg_en    = 1'b1;
        mg_index = issue_idx;
        idx_d    = issue_idx;
        state_d  = mg_ack ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (mg_ack) state_d = S_DONE;
      end
      S_DONE: begin
        op_done = 1'b1;
        state_d = S_FENCE;
      end
      S_FENCE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A value at or below Wired (or zero) reloads the top; Wired >= top pins it there.
  always_comb begin
    random_d = random_q;
    if (state_q != S_WAIT) begin
      if (random_q <= cp0_wired || random_q == '0) random_d = RAND_TOP;
      else                                          random_d = random_q - IDX_W'(1);
    end
  end

  assign random    = random_q;
  assign mg_code   = code_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      random_q    <= RAND_TOP;
      code_q      <= 2'd0;
      idx_q       <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      random_q    <= random_d;
      code_q      <= code_d;
      idx_q       <= idx_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
    end
  end

`ifdef TLB_SCHED_PERF_EN
  logic [31:0] perf_lookups_q, perf_lookups_d;
  logic [31:0] perf_conflicts_q, perf_conflicts_d;
  logic [31:0] perf_op_stall_q, perf_op_stall_d;

  always_comb begin
    perf_lookups_d   = perf_lookups_q + {31'd0, lk_valid};
    perf_conflicts_d = perf_conflicts_q + {31'd0, (state_q == S_IDLE) & if_req & dm_req};
    perf_op_stall_d  = perf_op_stall_q + {31'd0, state_q != S_IDLE};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lookups_q   <= '0;
      perf_conflicts_q <= '0;
      perf_op_stall_q  <= '0;
    end else begin
      perf_lookups_q   <= perf_lookups_d;
      perf_conflicts_q <= perf_conflicts_d;
      perf_op_stall_q  <= perf_op_stall_d;
    end
  end

  assign perf_lookups   = perf_lookups_q;
  assign perf_conflicts = perf_conflicts_q;
  assign perf_op_stall  = perf_op_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlb_access_sched.sv
// Directed bench for tlb_access_sched: arbitration, op sequencing, Random and reset behaviour.
`default_nettype none

module tb_tlb_access_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req, dm_req, dm_wr, op_req, mg_ack;
  logic [19:0] if_vpn, dm_vpn;
  logic [1:0]  op_code;
  logic [4:0]  cp0_index, cp0_wired;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, op_done;
  logic        lk_valid, lk_sel, lk_wr, mg_en;
  logic [19:0] lk_vpn;
  logic [1:0]  mg_code;
  logic [4:0]  random, mg_index;
`ifdef TLB_SCHED_PERF_EN
  logic [31:0] perf_lookups, perf_conflicts, perf_op_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tlb_access_sched #(.TLB_ENTRIES(32), .IDX_W(5), .STARVE_MAX(3)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_vpn(if_vpn), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_vpn(dm_vpn), .dm_wr(dm_wr), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .op_req(op_req), .op_code(op_code), .cp0_index(cp0_index), .cp0_wired(cp0_wired),
    .random(random), .op_done(op_done),
    .lk_valid(lk_valid), .lk_vpn(lk_vpn), .lk_sel(lk_sel), .lk_wr(lk_wr),
    .mg_en(mg_en), .mg_code(mg_code), .mg_index(mg_index), .mg_ack(mg_ack)
`ifdef TLB_SCHED_PERF_EN
    , .perf_lookups(perf_lookups), .perf_conflicts(perf_conflicts), .perf_op_stall(perf_op_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    logic exp_d, exp_i, prev_d, prev_i;
    resetn = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_wr = 1'b0; op_req = 1'b0; mg_ack = 1'b0;
    if_vpn = 20'h0; dm_vpn = 20'h0; op_code = 2'd0; cp0_index = 5'd0; cp0_wired = 5'd0;

    // Reset state, with requests pending to confirm grants stay low
    smp();
    chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
    chk("rst_lk_valid", {31'd0, lk_valid}, 32'd0);
    chk("rst_lk_vpn", {12'd0, lk_vpn}, 32'd0);
    chk("rst_random", {27'd0, random}, 32'd31);
    chk("rst_mg_en", {31'd0, mg_en}, 32'd0);
    chk("rst_mg_code", {30'd0, mg_code}, 32'd0);
    chk("rst_mg_index", {27'd0, mg_index}, 32'd0);
    chk("rst_op_done", {31'd0, op_done}, 32'd0);
    chk("rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    if_req = 1'b0; dm_req = 1'b0;
    step();
    resetn = 1'b1;

    // Idle 40 cycles, wired = 0: Random walks 31..0 then reloads 31
    for (int k = 0; k < 40; k++) begin
      smp();
      chk("idle_random", {27'd0, random}, 32'(31 - (k % 32)));
      chk("idle_strobes", {29'd0, lk_valid, mg_en, op_done}, 32'd0);
      step();
    end

    // Both requesters held: D,D,D,I,D,D,D,I with rvalid one cycle behind
    if_req = 1'b1; dm_req = 1'b1; if_vpn = 20'h11111; dm_vpn = 20'h22222; dm_wr = 1'b1;
    prev_d = 1'b0; prev_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = ((i % 4) != 3);
      exp_i = ~exp_d;
      smp();
      chk("arb_dm_gnt", {31'd0, dm_gnt}, {31'd0, exp_d});
      chk("arb_if_gnt", {31'd0, if_gnt}, {31'd0, exp_i});
      chk("arb_lk_sel", {31'd0, lk_sel}, {31'd0, exp_d});
      chk("arb_lk_wr", {31'd0, lk_wr}, {31'd0, exp_d});
      chk("arb_lk_vpn", {12'd0, lk_vpn}, exp_d ? 32'h22222 : 32'h11111);
      chk("arb_dm_rvalid", {31'd0, dm_rvalid}, {31'd0, prev_d});
      chk("arb_if_rvalid", {31'd0, if_rvalid}, {31'd0, prev_i});
      prev_d = exp_d; prev_i = exp_i;
      step();
    end
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    smp();
    chk("arb_tail_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("arb_tail_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
    chk("arb_tail_lk_valid", {31'd0, lk_valid}, 32'd0);
    step();

    // TLBWI raised with a data grant at t
    dm_req = 1'b1; dm_vpn = 20'h33333; op_req = 1'b1; op_code = 2'd2; cp0_index = 5'd7;
    smp();
    chk("wi_t_dm_gnt", {31'd0, dm_gnt}, 32'd1);
    chk("wi_t_lk_vpn", {12'd0, lk_vpn}, 32'h33333);
    step();
    dm_req = 1'b0; if_req = 1'b1; if_vpn = 20'h44444;
    smp();
    chk("wi_t1_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
    chk("wi_t1_no_gnt", {31'd0, lk_valid}, 32'd0);
    chk("wi_t1_mg_en", {31'd0, mg_en}, 32'd0);
    step();
    smp();
    chk("wi_t2_mg_en", {31'd0, mg_en}, 32'd1);
    chk("wi_t2_mg_index", {27'd0, mg_index}, 32'd7);
    chk("wi_t2_mg_code", {30'd0, mg_code}, 32'd2);
    chk("wi_t2_no_gnt", {31'd0, lk_valid}, 32'd0);
    step();
    smp();
    chk("wi_t3_mg_en", {31'd0, mg_en}, 32'd0);
    chk("wi_t3_mg_index", {27'd0, mg_index}, 32'd7);
    chk("wi_t3_op_done", {31'd0, op_done}, 32'd0);
    step();
    mg_ack = 1'b1;
    smp();
    chk("wi_t4_op_done", {31'd0, op_done}, 32'd0);
    chk("wi_t4_mg_index", {27'd0, mg_index}, 32'd7);
    step();
    mg_ack = 1'b0;
    smp();
    chk("wi_t5_op_done", {31'd0, op_done}, 32'd1);
    chk("wi_t5_no_gnt", {31'd0, lk_valid}, 32'd0);
    step();
    op_req = 1'b0;
    smp();
    chk("wi_t6_op_done", {31'd0, op_done}, 32'd0);
    chk("wi_t6_no_gnt", {31'd0, lk_valid}, 32'd0);
    step();
    smp();
    chk("wi_t7_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("wi_t7_lk_vpn", {12'd0, lk_vpn}, 32'h44444);
    step();
    if_req = 1'b0;
    smp();
    chk("wi_t8_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    step();

    // Fresh reset with wired = 29, then TLBWR
    resetn = 1'b0; cp0_wired = 5'd29;
    #2;
    chk("wr_rst_random", {27'd0, random}, 32'd31);
    step();
    resetn = 1'b1;
    smp(); chk("wr_k0_random", {27'd0, random}, 32'd31); step();
    smp(); chk("wr_k1_random", {27'd0, random}, 32'd30); step();
    smp(); chk("wr_k2_random", {27'd0, random}, 32'd29); step();
    smp(); chk("wr_k3_random", {27'd0, random}, 32'd31); step();
    smp(); chk("wr_k4_random", {27'd0, random}, 32'd30); step();
    op_req = 1'b1; op_code = 2'd3;
    smp(); chk("wr_k5_random", {27'd0, random}, 32'd29); step();
    smp(); chk("wr_k6_random", {27'd0, random}, 32'd31); chk("wr_k6_mg_en", {31'd0, mg_en}, 32'd0); step();
    smp();
    chk("wr_k7_mg_en", {31'd0, mg_en}, 32'd1);
    chk("wr_k7_random", {27'd0, random}, 32'd30);
    chk("wr_k7_mg_index", {27'd0, mg_index}, 32'd30);
    chk("wr_k7_mg_code", {30'd0, mg_code}, 32'd3);
    step();
    for (int k = 8; k <= 10; k++) begin
      if (k == 10) mg_ack = 1'b1;
      smp();
      chk("wr_wait_mg_index", {27'd0, mg_index}, 32'd30);
      chk("wr_wait_random", {27'd0, random}, 32'd29);
      chk("wr_wait_op_done", {31'd0, op_done}, 32'd0);
      step();
    end
    mg_ack = 1'b0;
    smp(); chk("wr_k11_op_done", {31'd0, op_done}, 32'd1); chk("wr_k11_random", {27'd0, random}, 32'd29); step();
    op_req = 1'b0;
    smp(); chk("wr_k12_random", {27'd0, random}, 32'd31); chk("wr_k12_op_done", {31'd0, op_done}, 32'd0); step();

    // TLBWI abandoned by reset while in WAIT
    op_req = 1'b1; op_code = 2'd2; cp0_index = 5'd5;
    step(); step(); step();
    smp();
    chk("ab_wait_mg_index", {27'd0, mg_index}, 32'd5);
    chk("ab_wait_mg_code", {30'd0, mg_code}, 32'd2);
    if_req = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("ab_rst_mg_index", {27'd0, mg_index}, 32'd0);
    chk("ab_rst_mg_code", {30'd0, mg_code}, 32'd0);
    chk("ab_rst_mg_en", {31'd0, mg_en}, 32'd0);
    chk("ab_rst_random", {27'd0, random}, 32'd31);
    chk("ab_rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("ab_rst_op_done", {31'd0, op_done}, 32'd0);
    op_req = 1'b0; if_req = 1'b0; cp0_wired = 5'd31; mg_ack = 1'b1;
    step();
    resetn = 1'b1;
    // Stale acks must not produce op_done; wired = 31 pins Random at 31
    for (int k = 0; k < 10; k++) begin
      if (k == 2) mg_ack = 1'b0;
      smp();
      chk("post_op_done", {31'd0, op_done}, 32'd0);
      chk("post_mg_en", {31'd0, mg_en}, 32'd0);
      chk("wired31_random", {27'd0, random}, 32'd31);
      step();
    end

    // TLBP with mg_ack in the ISSUE cycle
    op_req = 1'b1; op_code = 2'd0; cp0_index = 5'd9;
    step();
    step();
    mg_ack = 1'b1;
    smp();
    chk("p_mg_en", {31'd0, mg_en}, 32'd1);
    chk("p_mg_index", {27'd0, mg_index}, 32'd0);
    chk("p_mg_code", {30'd0, mg_code}, 32'd0);
    step();
    mg_ack = 1'b0;
    smp();
    chk("p_op_done", {31'd0, op_done}, 32'd1);
    chk("p_mg_en_off", {31'd0, mg_en}, 32'd0);
    step();
    op_req = 1'b0;
    smp();
    chk("p_op_done_off", {31'd0, op_done}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
